fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, issues one-outstanding-request reads on the instruction bus, and loads the fetch/decode pipeline register (instruction, pc_plus_4) consumed by decode. It obeys the fetch entry of the hazard stall/flush bundle and accepts a single redirect (taken beq from memory, j from decode), discarding any stale in-flight or buffered instruction.

---
 rtl/fetch_stage.sv | 191 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, keeps
// at most one read outstanding on the instruction bus, and loads the
// fetch/decode pipeline register consumed by decode. A redirect (taken branch
// or jump) replaces the PC and discards any stale in-flight or parked word.
//
// Ports
//   clk, resetn       clock (rising edge), asynchronous active-low reset
//   ireq_valid/addr   instruction read request, held stable until data_ok
//   iresp_data_ok     response valid this cycle, retires the request
//   iresp_data        instruction word returned with iresp_data_ok
//   redirect_valid/pc change of flow request and its target
//   stall, flush      hazard-unit controls for the F/D register
//   fd_valid          F/D register holds a real instruction
//   fd_instruction    F/D instruction word (0 when bubble)
//   fd_pc_plus_4      F/D PC + 4
//   fetch_wait        combinational: an instruction is not delivered this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        fd_valid,
    output logic [31:0] fd_instruction,
    output logic [31:0] fd_pc_plus_4,
    output logic        fetch_wait
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSN_STEP = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus_4;
    } fd_reg_t;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus_4;
    } hold_buf_t;

    logic [1:0]      state_q,      state_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] req_addr_q,   req_addr_d;
    hold_buf_t       hold_q,       hold_d;
    fd_reg_t         fd_q,         fd_d;
    logic            ireq_valid_q, ireq_valid_d;

    logic            deliver;
    hold_buf_t       deliver_word;
    logic [XLEN-1:0] req_addr_next;
    logic [XLEN-1:0] pc_next;

    // Sequential successors of the request address and the PC (mod 2^32).
    assign req_addr_next = req_addr_q + XLEN'(INSN_STEP);
    assign pc_next       = pc_q + XLEN'(INSN_STEP);

    // Next-state, PC bookkeeping and F/D load selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_word = '0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                req_addr_d = pc_q;
            end

            S_REQ: begin
                if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        // Word belongs to the old path: drop it, refetch at target.
                        pc_d       = redirect_pc;
                        req_addr_d = redirect_pc;
                    end else if (!stall) begin
                        deliver                  = 1'b1;
                        deliver_word.instruction = iresp_data;
                        deliver_word.pc_plus_4   = req_addr_next;
                        pc_d                     = req_addr_next;
                        req_addr_d               = req_addr_next;
                    end else begin
                        // Decode cannot take it yet; park it and stop fetching.
                        hold_d.instruction = iresp_data;
                        hold_d.pc_plus_4   = req_addr_next;
                        state_d            = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn; its response must be drained.
                    pc_d    = redirect_pc;
                    state_d = S_DISCARD;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    hold_d     = '0;
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_word = hold_q;
                    pc_d         = pc_next;
                    req_addr_d   = pc_next;
                    state_d      = S_REQ;
                end
            end

            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (iresp_data_ok) begin
                    // Stale word dropped; resume at the most recent target.
                    req_addr_d = pc_d;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // F/D priority: flush, then stall, then a delivered word, else bubble.
        if (flush) begin
            fd_d = '0;
        end else if (stall) begin
            fd_d = fd_q;
        end else if (deliver) begin
            fd_d.valid       = 1'b1;
            fd_d.instruction = deliver_word.instruction;
            fd_d.pc_plus_4   = deliver_word.pc_plus_4;
        end else begin
            fd_d = '0;
        end

        ireq_valid_d = (state_d == S_REQ) || (state_d == S_DISCARD);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_q       <= '0;
            fd_q         <= '0;
            ireq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_q       <= hold_d;
            fd_q         <= fd_d;
            ireq_valid_q <= ireq_valid_d;
        end
    end

    assign ireq_valid     = ireq_valid_q;
    assign ireq_addr      = req_addr_q;
    assign fd_valid       = fd_q.valid;
    assign fd_instruction = fd_q.instruction;
    assign fd_pc_plus_4   = fd_q.pc_plus_4;

    // Status to the hazard unit: low only while holding a parked word or when
    // a live response is accepted this cycle.
    assign fetch_wait = (state_q != S_HOLD) &&
                        !((state_q == S_REQ) && iresp_data_ok && !redirect_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed and randomized stimulus for fetch_stage, checked every cycle
// against a transaction-level model of the fetch rules (request in flight,
// stale response owed, parked word) plus directed constant expectations.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        flush;
    logic        fd_valid;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc_plus_4;
    logic        fetch_wait;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit          m_started;
    bit          m_req;
    bit          m_stale;
    bit          m_parked;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_park_instr;
    logic [31:0] m_park_pc4;
    bit          m_fd_valid;
    logic [31:0] m_fd_instr;
    logic [31:0] m_fd_pc4;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .flush          (flush),
        .fd_valid       (fd_valid),
        .fd_instruction (fd_instruction),
        .fd_pc_plus_4   (fd_pc_plus_4),
        .fetch_wait     (fetch_wait)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_req      = 1'b0;
        m_stale    = 1'b0;
        m_parked   = 1'b0;
        m_pc       = RESET_PC;
        m_addr     = RESET_PC;
        m_park_instr = 32'h0;
        m_park_pc4   = 32'h0;
        m_fd_valid = 1'b0;
        m_fd_instr = 32'h0;
        m_fd_pc4   = 32'h0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, ".ireq_valid"}, 32'(ireq_valid), 32'd0);
        check({where, ".ireq_addr"},  ireq_addr, RESET_PC);
        check({where, ".fd_valid"},   32'(fd_valid), 32'd0);
        check({where, ".fd_instr"},   fd_instruction, 32'h0);
        check({where, ".fd_pc4"},     fd_pc_plus_4, 32'h0);
        check({where, ".fetch_wait"}, 32'(fetch_wait), 32'd1);
    endtask

    // One clock cycle: compare registered outputs, apply inputs, compare the
    // combinational status, advance the model, move to the next falling edge.
    task automatic step(input bit ok, input logic [31:0] data, input bit rd,
                        input logic [31:0] rpc, input bit st, input bit fl);
        bit          deliv;
        logic [31:0] d_instr;
        logic [31:0] d_pc4;
        deliv   = 1'b0;
        d_instr = 32'h0;
        d_pc4   = 32'h0;

        check("ireq_valid", 32'(ireq_valid), 32'(m_req));
        check("ireq_addr",  ireq_addr, m_addr);
        check("fd_valid",   32'(fd_valid), 32'(m_fd_valid));
        check("fd_instr",   fd_instruction, m_fd_instr);
        check("fd_pc4",     fd_pc_plus_4, m_fd_pc4);

        iresp_data_ok  = ok;
        iresp_data     = data;
        redirect_valid = rd;
        redirect_pc    = rpc;
        stall          = st;
        flush          = fl;
        #1;
        check("fetch_wait", 32'(fetch_wait),
              32'(!m_parked && !(m_req && !m_stale && ok && !rd)));

        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = m_pc;
        end else if (m_parked) begin
            if (rd) begin
                m_parked = 1'b0;
                m_pc     = rpc;
                m_addr   = rpc;
                m_req    = 1'b1;
            end else if (!st) begin
                deliv    = 1'b1;
                d_instr  = m_park_instr;
                d_pc4    = m_park_pc4;
                m_parked = 1'b0;
                m_pc     = m_pc + 32'd4;
                m_addr   = m_pc;
                m_req    = 1'b1;
            end
        end else if (m_req && m_stale) begin
            if (rd) m_pc = rpc;
            if (ok) begin
                m_stale = 1'b0;
                m_addr  = m_pc;
            end
        end else if (m_req) begin
            if (ok && rd) begin
                m_pc   = rpc;
                m_addr = rpc;
            end else if (ok && !st) begin
                deliv   = 1'b1;
                d_instr = data;
                d_pc4   = m_addr + 32'd4;
                m_addr  = m_addr + 32'd4;
                m_pc    = m_addr;
            end else if (ok) begin
                m_parked     = 1'b1;
                m_park_instr = data;
                m_park_pc4   = m_addr + 32'd4;
                m_req        = 1'b0;
            end else if (rd) begin
                m_pc    = rpc;
                m_stale = 1'b1;
            end
        end

        if (fl) begin
            m_fd_valid = 1'b0; m_fd_instr = 32'h0; m_fd_pc4 = 32'h0;
        end else if (!st) begin
            m_fd_valid = deliv; m_fd_instr = d_instr; m_fd_pc4 = d_pc4;
        end

        @(negedge clk);
    endtask

    initial begin
        logic        r_ok, r_rd, r_st, r_fl;
        logic [31:0] r_pc;

        resetn = 1'b0;
        iresp_data_ok = 1'b0; iresp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall = 1'b0; flush = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Leave IDLE; first request visible after the next edge.
        step(0, 32'h0, 0, 32'h0, 0, 0);
        check("first_req.valid", 32'(ireq_valid), 32'd1);
        check("first_req.addr",  ireq_addr, 32'hBFC0_0000);

        // Back-to-back fetch, data = address.
        for (int i = 0; i < 4; i++) step(1, m_addr, 0, 32'h0, 0, 0);
        check("b2b.fd_valid", 32'(fd_valid), 32'd1);
        check("b2b.fd_instr", fd_instruction, 32'hBFC0_000C);
        check("b2b.fd_pc4",   fd_pc_plus_4,   32'hBFC0_0010);
        check("b2b.addr",     ireq_addr,      32'hBFC0_0010);

        // Slow response: request held, bubbles meanwhile.
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 32'h0, 0, 0);
        check("slow.fd_valid", 32'(fd_valid), 32'd0);
        check("slow.addr",     ireq_addr,     32'hBFC0_0010);
        step(1, m_addr, 0, 32'h0, 0, 0);

        // Stall as the word arrives: parked, bus idle, F/D unchanged.
        step(1, 32'h1234_5678, 0, 32'h0, 1, 0);
        check("hold.ireq_valid", 32'(ireq_valid), 32'd0);
        check("hold.fd_instr",   fd_instruction, 32'hBFC0_0010);
        step(0, 32'h0, 0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0);
        check("release.fd_instr", fd_instruction, 32'h1234_5678);
        check("release.fd_pc4",   fd_pc_plus_4,   32'hBFC0_0018);
        check("release.addr",     ireq_addr,      32'hBFC0_0018);

        // Redirect while a request is outstanding: stale word dropped.
        step(0, 32'h0, 1, 32'h8000_0100, 0, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
        check("discard.addr",     ireq_addr, 32'h8000_0100);
        check("discard.fd_valid", 32'(fd_valid), 32'd0);
        step(1, m_addr, 0, 32'h0, 0, 0);

        // Redirect coinciding with data_ok, then flush beating stall.
        step(1, 32'hCAFE_F00D, 1, 32'h8000_0200, 0, 1);
        check("redir_ok.addr", ireq_addr, 32'h8000_0200);
        step(1, m_addr, 0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 32'h0, 1, 1);
        check("flush_stall.valid", 32'(fd_valid), 32'd0);
        check("flush_stall.instr", fd_instruction, 32'h0);
        check("flush_stall.pc4",   fd_pc_plus_4,   32'h0);

        // PC wrap at the top of the address space.
        step(1, 32'h0, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 32'h0BAD_C0DE, 0, 32'h0, 0, 0);
        check("wrap.fd_pc4", fd_pc_plus_4, 32'h0);
        check("wrap.addr",   ireq_addr,    32'h0);

        // Randomized traffic; data_ok only while a request is on the bus.
        for (int i = 0; i < 600; i++) begin
            r_ok = m_req ? ($urandom_range(0, 2) != 0) : 1'b0;
            r_rd = ($urandom_range(0, 5) == 0);
            r_st = ($urandom_range(0, 3) == 0);
            r_fl = ($urandom_range(0, 7) == 0);
            r_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step(r_ok, $urandom(), r_rd, r_pc, r_st, r_fl);
        end

        // Reach a live request, park a word, then reset asynchronously.
        for (int k = 0; k < 4; k++) begin
            if (!(m_req && !m_stale)) step(m_req, $urandom(), 0, 32'h0, 0, 0);
        end
        step(1, 32'h55AA_55AA, 0, 32'h0, 1, 0);
        check("pre_reset.ireq_valid", 32'(ireq_valid), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        // Late data_ok in IDLE must be ignored.
        step(1, 32'hBAD0_BAD0, 0, 32'h0, 0, 0);
        check("restart.addr",  ireq_addr, RESET_PC);
        check("restart.valid", 32'(ireq_valid), 32'd1);
        step(1, m_addr, 0, 32'h0, 0, 0);
        check("restart.fd_instr", fd_instruction, RESET_PC);
        check("restart.fd_pc4",   fd_pc_plus_4,   32'hBFC0_0004);
        step(0, 32'h0, 0, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
